// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode/hazard constants: PC width, bubble encoding, reset PC
// and the IF/ID pipeline record.
package fetch_stage_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic               valid;
  } if_id_t;

  // Sequential fetch increment; wraps modulo 2^32 by construction.
  function automatic logic [PC_W-1:0] pc_increment(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

  function automatic if_id_t if_id_bubble(input logic [INSTR_W-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg_if_id.sv
// IF/ID pipeline register: reset > flush > stall > load.
module pipe_reg_if_id
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [PC_W-1:0]    pc_plus4_in,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               valid
);

  if_id_t if_id_reg;
  if_id_t if_id_next;

  // Flush deliberately beats stall so a redirect never leaves a stale slot.
  always_comb begin
    if_id_next = if_id_reg;
    if (flush) begin
      if_id_next = if_id_bubble(NOP_INSTR);
    end else if (!stall) begin
      if_id_next.instr    = instr_in;
      if_id_next.pc       = pc_in;
      if_id_next.pc_plus4 = pc_plus4_in;
      if_id_next.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_reg <= if_id_bubble(NOP_INSTR);
    end else begin
      if_id_reg <= if_id_next;
    end
  end

  assign instr    = if_id_reg.instr;
  assign pc       = if_id_reg.pc;
  assign pc_plus4 = if_id_reg.pc_plus4;
  assign valid    = if_id_reg.valid;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with PC register and IF/ID register.
// Optional performance counters are built when PERF_CNT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    PCF,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        redirect_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_plus4;
  logic            flush_d;

  assign pc_plus4 = pc_increment(pc_reg);

  // A redirect must win over a stall, otherwise the branch target is lost.
  always_comb begin
    pc_next = pc_plus4;
    if (PCSrcE) begin
      pc_next = PCTargetE;
    end else if (StallF) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign PCF       = pc_reg;
  assign imem_addr = pc_reg;

  // The wrong-path instruction in Decode is squashed here on every redirect.
  assign flush_d = FlushD | PCSrcE;

  pipe_reg_if_id #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_d),
    .stall       (StallD),
    .instr_in    (imem_rdata),
    .pc_in       (pc_reg),
    .pc_plus4_in (pc_plus4),
    .instr       (InstrD),
    .pc          (PCD),
    .pc_plus4    (PCPlus4D),
    .valid       (ValidD)
  );

`ifdef PERF_CNT_EN
  logic [31:0] redirect_cnt_reg;
  logic [31:0] stall_cnt_reg;

  // A stall edge that coincides with a redirect counts only as a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt_reg <= '0;
      stall_cnt_reg    <= '0;
    end else if (PCSrcE) begin
      redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
    end else if (StallF) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_reg;
  assign stall_cnt    = stall_cnt_reg;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core. It holds the program counter and drives the instruction-memory address. It selects the next PC from PC+4 or the Execute-stage redirect (PCSrcE/PCTargetE from branch control), and it registers the fetched instruction into Decode. It applies the hazard unit's stall and flush requests, and it flushes itself on a taken branch or jump.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) written into IF/ID on flush

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- PCSrcE  input  1  redirect request from branch control (taken branch or jump in Execute)
- PCTargetE  input  32  redirect target computed in Execute
- StallF  input  1  hold PCF (hazard unit)
- StallD  input  1  hold IF/ID register (hazard unit)
- FlushD  input  1  external bubble request for IF/ID (hazard unit)
- imem_addr  output  32  instruction-memory address, equal to PCF
- imem_rdata  input  32  instruction word; combinational read of imem_addr in the same cycle
- PCF  output  32  current fetch PC
- InstrD  output  32  registered instruction for Decode
- PCD  output  32  registered PC of InstrD
- PCPlus4D  output  32  registered PCD+4
- ValidD  output  1  InstrD is a real fetched instruction (0 = bubble)
- redirect_cnt  output  32  only with PERF_CNT_EN
- stall_cnt  output  32  only with PERF_CNT_EN

## Operation
- PCPlus4F = PCF + 4, 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- PCF next-value priority: reset → RESET_PC; else PCSrcE → PCTargetE; else StallF → hold; else PCPlus4F.
- PCSrcE overrides StallF. The redirect is never lost.
- No alignment check. PCTargetE is loaded as given; bits [1:0] pass through.
- IF/ID next-value priority:
  - reset → {InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0}
  - else (FlushD | PCSrcE) → same bubble values
  - else StallD → hold all four
  - else load {imem_rdata, PCF, PCPlus4F, 1}
- The block ORs PCSrcE into the IF/ID flush internally. The hazard unit does not need to re-issue FlushD for redirects.
- Flush beats StallD when both are asserted.
- No state machine beyond the PC and IF/ID registers. No handshake with memory; imem is assumed single-cycle.

## Timing
- Reset values: PCF=RESET_PC, imem_addr=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, counters=0.
- Reset mid-operation: reset wins over every other input on that edge.
- First valid instruction: reset deasserts before edge N, so InstrD(RESET_PC) is valid after edge N.
- Fetch-to-Decode latency: 1 cycle.
- Redirect: PCSrcE sampled high at edge N.
  - PCF=PCTargetE after N.
  - The instruction at PCTargetE reaches InstrD after N+1.
  - Branch penalty is 2 bubbles: the Decode slot is flushed here; the Execute slot is flushed by the hazard unit.
- Stall: StallF=StallD=1 at edge N, so PCF and IF/ID hold exactly one cycle per asserted edge.
- imem_addr is combinational from PCF (no register).

## Configuration
- PERF_CNT_EN defined:
  - redirect_cnt increments on every edge with PCSrcE=1 and reset=0.
  - stall_cnt increments on every edge with StallF=1, PCSrcE=0 and reset=0.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- PERF_CNT_EN undefined: counter registers and both ports are absent. Fetch behaviour is identical.

## Structure
- Shared package: NOP_INSTR, RESET_PC default, and the PC-width constant (32). This package is reused by the decode and hazard blocks.
- One sub-module, pipe_reg_if_id: the IF/ID register with flush/stall/load priority.
- The PC register and next-PC mux stay in the top level.
- Perf counters are inline, inside an `ifdef PERF_CNT_EN` region.

## Test plan
- Reset then free-run, with imem returning 0x00A00093 at PC 0 → PCF sequence 0,4,8,C; InstrD=0x00A00093 with PCD=0 and ValidD=1 one cycle after reset release.
- PCSrcE=1 with PCTargetE=0x40 while PCF=0x10 → next PCF=0x40; InstrD=0x00000013 and ValidD=0 for that cycle; InstrD=word@0x40 with PCD=0x40 the cycle after.
- StallF=StallD=1 for 2 cycles at PCF=0x8 → PCF stays 0x8 and IF/ID holds PCD=0x4 for both cycles; the sequence resumes 0xC then 0x10.
- PCSrcE=1 and StallF=StallD=1 on the same edge, target 0x100 → PCF=0x100 and IF/ID bubble.
- PCF=0xFFFF_FFFC free-run → next PCF=0x0; PCPlus4D=0x0 for the instruction at 0xFFFF_FFFC. Separately, reset asserted mid-stall → all outputs return to reset values on the next edge.
- PERF_CNT_EN build: 3 redirects and 5 stall cycles → redirect_cnt=3 and stall_cnt=5; reset → both 0.
